// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline freeze/flush control with SRAM access sequencing and watchdog.
// Define PIPE_FORWARDING_EN to stall only on load-use hazards.
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       id_src1,
   input  logic [3:0]       id_src2,
   input  logic             id_use_src1,
   input  logic             id_two_src,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             sram_ready,
   output logic             sram_start,
   output logic             freeze_pc,
   output logic             freeze_ifid,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             freeze_exmem,
   output logic             mem_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

   typedef enum logic {
      MEM_IDLE,
      MEM_BUSY
   } mem_state_t;

   mem_state_t        state_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic              mem_err_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;

   // Index 0 is src1, index 1 is src2.
   logic [1:0][3:0] id_src;
   logic [1:0]      src_used;
   logic [1:0]      exe_hit;

   assign id_src   = {id_src2, id_src1};
   assign src_used = {id_two_src, id_use_src1};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_exe_hit
         assign exe_hit[gi] = src_used[gi] & (id_src[gi] == exe_dest);
      end
   endgenerate

   logic hazard;

`ifdef PIPE_FORWARDING_EN
   assign hazard = exe_wb_en & exe_mem_r_en & (|exe_hit);
`else
   logic [1:0] mem_hit;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_mem_hit
         assign mem_hit[gi] = src_used[gi] & (id_src[gi] == mem_dest);
      end
   endgenerate

   assign hazard = (exe_wb_en & (|exe_hit)) | (mem_wb_en & (|mem_hit));
`endif

   logic mem_idle;
   logic mem_busy;
   logic timeout_hit;
   logic mem_wait;

   // No access may be launched while reset is held.
   assign mem_idle    = (state_reg == MEM_IDLE) & rst;
   assign mem_busy    = (state_reg == MEM_BUSY);
   assign timeout_hit = mem_busy & ~sram_ready & (wait_cnt_reg == WAIT_MAX);
   assign mem_wait    = (mem_idle & mem_req) | (mem_busy & ~sram_ready & ~timeout_hit);

   assign sram_start   = mem_idle & mem_req;
   assign freeze_pc    = mem_wait | (~branch_taken & hazard);
   assign freeze_ifid  = freeze_pc;
   assign flush_ifid   = ~mem_wait & branch_taken;
   assign flush_idex   = ~mem_wait & (branch_taken | hazard);
   assign freeze_exmem = mem_wait;
   // An abandoned access must not write back garbage.
   assign mem_bubble   = mem_wait | timeout_hit;
   assign mem_err      = mem_err_reg;
   assign stall_cnt    = stall_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= MEM_IDLE;
         wait_cnt_reg <= '0;
         mem_err_reg  <= 1'b0;
      end else begin
         case (state_reg)
            MEM_IDLE: begin
               if (mem_req) begin
                  state_reg    <= MEM_BUSY;
                  wait_cnt_reg <= '0;
               end
            end
            MEM_BUSY: begin
               if (sram_ready) begin
                  state_reg <= MEM_IDLE;
               end else if (timeout_hit) begin
                  state_reg   <= MEM_IDLE;
                  mem_err_reg <= 1'b1;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            default: state_reg <= MEM_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_reg <= '0;
      end else if (freeze_pc && (stall_cnt_reg != {CNT_W{1'b1}})) begin
         stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized bench for pipeline_hazard_ctrl against a cycle-indexed reference
// model, plus directed hazard, branch, SRAM-wait and watchdog scenarios.
module tb_pipeline_hazard_ctrl;

   localparam int TO  = 8;
   localparam int CW  = 8;
   localparam int SAT = 255;
`ifdef PIPE_FORWARDING_EN
   localparam int ALU_STALL = 0;
`else
   localparam int ALU_STALL = 1;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [3:0]    id_src1, id_src2, exe_dest, mem_dest;
   logic          id_use_src1, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic          branch_taken, mem_req, sram_ready;
   logic          sram_start, freeze_pc, freeze_ifid, flush_ifid, flush_idex;
   logic          freeze_exmem, mem_bubble, mem_err;
   logic [CW-1:0] stall_cnt;

   pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_use_src1(id_use_src1), .id_two_src(id_two_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .mem_req(mem_req), .sram_ready(sram_ready),
      .sram_start(sram_start), .freeze_pc(freeze_pc), .freeze_ifid(freeze_ifid),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .freeze_exmem(freeze_exmem),
      .mem_bubble(mem_bubble), .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   // Reference model: an access is a transaction opened at cycle m_start.
   bit m_busy, m_err;
   int m_start, m_cyc, m_stall;
   int starts_seen, freezes_seen, flushes_seen;
   bit last_bubble, last_freeze, last_flush_idex, last_flush_ifid;

   function automatic bit raw(input logic [3:0] d, input bit we);
      return we && ((id_use_src1 && id_src1 == d) || (id_two_src && id_src2 == d));
   endfunction

   task automatic step();
      bit hz, timeout_now, wait_now, e_start, e_fpc, e_fl_if, e_fl_id, e_bub;
      int busy_idx;
      #1;
      if (!rst) begin
         m_busy = 0; m_err = 0; m_stall = 0; m_cyc = 0; m_start = 0;
      end
`ifdef PIPE_FORWARDING_EN
      hz = raw(exe_dest, exe_wb_en && exe_mem_r_en);
`else
      hz = raw(exe_dest, exe_wb_en) || raw(mem_dest, mem_wb_en);
`endif
      busy_idx    = m_cyc - m_start - 1;
      timeout_now = m_busy && !sram_ready && (busy_idx == TO);
      wait_now    = rst && ((!m_busy && mem_req) || (m_busy && !sram_ready && !timeout_now));
      e_start     = rst && !m_busy && mem_req;
      e_fpc       = wait_now || (!branch_taken && hz);
      e_fl_if     = !wait_now && branch_taken;
      e_fl_id     = !wait_now && (branch_taken || hz);
      e_bub       = wait_now || timeout_now;

      check("sram_start",   32'(sram_start),   32'(e_start));
      check("freeze_pc",    32'(freeze_pc),    32'(e_fpc));
      check("freeze_ifid",  32'(freeze_ifid),  32'(e_fpc));
      check("flush_ifid",   32'(flush_ifid),   32'(e_fl_if));
      check("flush_idex",   32'(flush_idex),   32'(e_fl_id));
      check("freeze_exmem", 32'(freeze_exmem), 32'(wait_now));
      check("mem_bubble",   32'(mem_bubble),   32'(e_bub));
      check("mem_err",      32'(mem_err),      32'(m_err));
      check("stall_cnt",    32'(stall_cnt),    32'(m_stall));

      if (sram_start) starts_seen++;
      if (freeze_pc)  freezes_seen++;
      if (flush_ifid) flushes_seen++;
      last_bubble     = mem_bubble;
      last_freeze     = freeze_pc;
      last_flush_idex = flush_idex;
      last_flush_ifid = flush_ifid;

      if (rst) begin
         if (!m_busy && mem_req) begin
            m_busy  = 1;
            m_start = m_cyc;
         end else if (m_busy && (sram_ready || timeout_now)) begin
            m_busy = 0;
            if (!sram_ready) m_err = 1;
         end
         if (e_fpc && m_stall < SAT) m_stall++;
         m_cyc++;
      end
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      id_src1 = 4'd0; id_src2 = 4'd0; id_use_src1 = 0; id_two_src = 0;
      exe_dest = 4'd0; exe_wb_en = 0; exe_mem_r_en = 0;
      mem_dest = 4'd0; mem_wb_en = 0;
      branch_taken = 0; mem_req = 0; sram_ready = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 0;
      step();
      rst = 1;
   endtask

   task automatic set_load_use(input bit is_load);
      exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = is_load;
      id_src1 = 4'd3; id_use_src1 = 1;
      id_src2 = 4'd9; id_two_src = 0;
   endtask

   int s0, f0, fl0;

   initial begin
      clear_inputs();
      rst = 0;
      @(negedge clk);

      // Reset held with a pending request
      mem_req = 1;
      step(); step();
      check("rst_start", 32'(sram_start), 32'd0);
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_err",   32'(mem_err), 32'd0);
      rst = 1;
      s0 = starts_seen;
      step();
      check("rel_start", 32'(starts_seen - s0), 32'd1);
      mem_req = 0; sram_ready = 1;
      step();
      $display("reset: start pulses after release = %0d", starts_seen - s0);

      // Load-use stall
      do_reset();
      set_load_use(1);
      step();
      check("lu_freeze", 32'(last_freeze), 32'd1);
      check("lu_flush_idex", 32'(last_flush_idex), 32'd1);
      clear_inputs();
      step();
      check("lu_release", 32'(last_freeze), 32'd0);
      check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
      $display("load-use: stall_cnt = %0d", stall_cnt);

      // ALU producer
      do_reset();
      set_load_use(0);
      step();
      check("alu_freeze", 32'(last_freeze), 32'(ALU_STALL));
      $display("alu producer: freeze_pc = %0d", last_freeze);

      // Branch overrides hazard
      do_reset();
      set_load_use(1);
      branch_taken = 1;
      step();
      check("br_flush_ifid", 32'(last_flush_ifid), 32'd1);
      check("br_flush_idex", 32'(last_flush_idex), 32'd1);
      check("br_freeze_pc", 32'(last_freeze), 32'd0);
      $display("branch+hazard: flush_ifid=%0d flush_idex=%0d freeze_pc=%0d",
               last_flush_ifid, last_flush_idex, last_freeze);

      // SRAM wait, ready on BUSY cycle with wait count 4
      do_reset();
      s0 = starts_seen; f0 = freezes_seen;
      mem_req = 1;
      for (int i = 0; i < 5; i++) step();
      sram_ready = 1;
      step();
      clear_inputs();
      step();
      check("sram_starts", 32'(starts_seen - s0), 32'd1);
      check("sram_frozen", 32'(freezes_seen - f0), 32'd5);
      check("sram_stall_cnt", 32'(stall_cnt), 32'd5);
      s0 = starts_seen;
      mem_req = 1;
      step();
      check("sram_idle_again", 32'(starts_seen - s0), 32'd1);
      mem_req = 0; sram_ready = 1;
      step();
      clear_inputs();
      $display("sram wait: frozen=%0d stall_cnt=%0d", freezes_seen - f0, stall_cnt);

      // Watchdog timeout
      do_reset();
      s0 = starts_seen;
      mem_req = 1;
      for (int i = 0; i < TO + 1; i++) step();
      check("to_err_early", 32'(mem_err), 32'd0);
      step();
      check("to_bubble", 32'(last_bubble), 32'd1);
      check("to_released", 32'(last_freeze), 32'd0);
      check("to_err", 32'(mem_err), 32'd1);
      check("to_starts", 32'(starts_seen - s0), 32'd1);
      mem_req = 0;
      for (int i = 0; i < 3; i++) step();
      check("to_err_sticky", 32'(mem_err), 32'd1);
      $display("timeout: mem_err=%0d", mem_err);

      // Branch pending during SRAM wait
      do_reset();
      fl0 = flushes_seen;
      mem_req = 1; branch_taken = 1;
      for (int i = 0; i < 3; i++) step();
      check("bw_no_flush", 32'(flushes_seen - fl0), 32'd0);
      sram_ready = 1;
      step();
      check("bw_flush_ifid", 32'(last_flush_ifid), 32'd1);
      check("bw_flush_idex", 32'(last_flush_idex), 32'd1);
      check("bw_released", 32'(last_freeze), 32'd0);
      clear_inputs();
      $display("branch during wait: flushes in wait=%0d", flushes_seen - fl0 - 1);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst          = ($urandom_range(0, 79) != 0);
         id_src1      = 4'($urandom_range(0, 3));
         id_src2      = 4'($urandom_range(0, 3));
         id_use_src1  = ($urandom_range(0, 1) == 1);
         id_two_src   = ($urandom_range(0, 1) == 1);
         exe_dest     = 4'($urandom_range(0, 3));
         exe_wb_en    = ($urandom_range(0, 1) == 1);
         exe_mem_r_en = ($urandom_range(0, 1) == 1);
         mem_dest     = 4'($urandom_range(0, 3));
         mem_wb_en    = ($urandom_range(0, 1) == 1);
         branch_taken = ($urandom_range(0, 4) == 0);
         mem_req      = ($urandom_range(0, 1) == 1);
         sram_ready   = ($urandom_range(0, 9) == 0);
         step();
      end
      rst = 1;
      $display("random: %0d cycles, %0d starts", 3000, starts_seen);

      // Stall counter saturation
      do_reset();
      set_load_use(1);
      for (int i = 0; i < SAT + 15; i++) step();
      check("stall_saturate", 32'(stall_cnt), 32'(SAT));
      $display("saturation: stall_cnt=%0d", stall_cnt);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
